// File: rtl/mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory-controller command port between NUM_REQ clients.
// Holds the grant through write data and steers read-return beats through an outstanding-read ID FIFO.
module mem_cmd_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 32,
    parameter int BLEN_W   = 8,
    parameter int RD_DEPTH = 4
) (
    input  logic                      clk_mem,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*BLEN_W-1:0] req_burst_len,
    output logic                      mc_cmd_valid,
    input  logic                      mc_cmd_ready,
    output logic [ADDR_W-1:0]         mc_cmd_addr,
    output logic                      mc_cmd_write,
    output logic [BLEN_W-1:0]         mc_cmd_burst_len,
    input  logic                      mc_wr_valid,
    input  logic                      mc_wr_ready,
    input  logic                      mc_rd_valid,
    input  logic                      mc_rd_ready,
    input  logic                      calibration_done,
    input  logic                      mc_error,
    output logic [NUM_REQ-1:0]        wr_owner,
    output logic [NUM_REQ-1:0]        rd_owner,
    output logic                      arb_error
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(RD_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [GW-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [GW-1:0] inc_mod_f(input logic [GW-1:0] v);
        if (v == GW'(NUM_REQ-1)) begin
            return '0;
        end else begin
            return v + GW'(1);
        end
    endfunction

    state_t              state_r, state_nxt_s;
    logic [GW-1:0]       grant_r, rr_ptr_r, win_idx_s, scan_s;
    logic                win_found_s, launch_s, accept_s, push_s, pop_s;
    logic                wr_beat_s, rd_beat_s, empty_s, full_s;
    logic                mc_cmd_valid_r, mc_cmd_write_r, arb_error_r, rd_loaded_r;
    logic [ADDR_W-1:0]   mc_cmd_addr_r;
    logic [BLEN_W-1:0]   mc_cmd_burst_len_r, wr_cnt_r, rd_cnt_r, rd_cnt_eff_s, head_len_s;
    logic [NUM_REQ-1:0]  elig_s;
    logic [PW:0]         wptr_r, rptr_r;
    logic [GW-1:0]       id_mem_r  [RD_DEPTH];
    logic [BLEN_W-1:0]   len_mem_r [RD_DEPTH];

    assign wr_beat_s = mc_wr_valid & mc_wr_ready;
    assign rd_beat_s = mc_rd_valid & mc_rd_ready;
    assign empty_s   = (wptr_r == rptr_r);
    assign full_s    = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
    // Reads are held back while there is no room to track their return.
    assign elig_s    = req_valid & (req_write | {NUM_REQ{~full_s}});
    assign accept_s  = (state_r == ST_ISSUE) && mc_cmd_ready;
    assign launch_s  = (state_r == ST_IDLE) && calibration_done && !arb_error_r && win_found_s;
    assign push_s    = accept_s && !mc_cmd_write_r;
    assign head_len_s   = len_mem_r[rptr_r[PW-1:0]];
    assign rd_cnt_eff_s = rd_loaded_r ? rd_cnt_r : head_len_s;
    assign pop_s        = rd_beat_s && !empty_s && (rd_cnt_eff_s == '0);

    assign req_ready        = accept_s ? onehot_f(grant_r) : '0;
    assign wr_owner         = (state_r == ST_WDATA) ? onehot_f(grant_r) : '0;
    assign rd_owner         = empty_s ? '0 : onehot_f(id_mem_r[rptr_r[PW-1:0]]);
    assign mc_cmd_valid     = mc_cmd_valid_r;
    assign mc_cmd_addr      = mc_cmd_addr_r;
    assign mc_cmd_write     = mc_cmd_write_r;
    assign mc_cmd_burst_len = mc_cmd_burst_len_r;
    assign arb_error        = arb_error_r;

    // Round-robin scan: first eligible requester starting at rr_ptr.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        scan_s      = rr_ptr_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found_s && elig_s[scan_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_s;
            end else begin
                win_idx_s   = win_idx_s;
            end
            scan_s = inc_mod_f(scan_s);
        end
    end

    // Next-state logic for the command FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) state_nxt_s = ST_ISSUE;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (mc_cmd_ready) state_nxt_s = mc_cmd_write_r ? ST_WDATA : ST_IDLE;
                else              state_nxt_s = ST_ISSUE;
            end
            ST_WDATA: begin
                if (wr_beat_s && (wr_cnt_r == '0)) state_nxt_s = ST_IDLE;
                else                               state_nxt_s = ST_WDATA;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command registers, grant, round-robin pointer and write-beat counter.
    always_ff @(posedge clk_mem) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            grant_r            <= '0;
            rr_ptr_r           <= '0;
            wr_cnt_r           <= '0;
            mc_cmd_valid_r     <= 1'b0;
            mc_cmd_addr_r      <= '0;
            mc_cmd_write_r     <= 1'b0;
            mc_cmd_burst_len_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (launch_s) begin
                grant_r            <= win_idx_s;
                mc_cmd_valid_r     <= 1'b1;
                mc_cmd_addr_r      <= req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
                mc_cmd_write_r     <= req_write[win_idx_s];
                mc_cmd_burst_len_r <= req_burst_len[int'(win_idx_s)*BLEN_W +: BLEN_W];
            end else if (accept_s) begin
                mc_cmd_valid_r <= 1'b0;
                rr_ptr_r       <= inc_mod_f(grant_r);
                if (mc_cmd_write_r) wr_cnt_r <= mc_cmd_burst_len_r;
            end else if ((state_r == ST_WDATA) && wr_beat_s && (wr_cnt_r != '0)) begin
                wr_cnt_r <= wr_cnt_r - BLEN_W'(1);
            end
        end
    end

    // Outstanding-read FIFO pointers and the head's remaining-beat counter.
    always_ff @(posedge clk_mem) begin
        if (rst) begin
            wptr_r      <= '0;
            rptr_r      <= '0;
            rd_cnt_r    <= '0;
            rd_loaded_r <= 1'b0;
        end else begin
            if (push_s) wptr_r <= wptr_r + (PW+1)'(1);
            if (pop_s) begin
                rptr_r      <= rptr_r + (PW+1)'(1);
                rd_cnt_r    <= '0;
                rd_loaded_r <= 1'b0;
            end else if (rd_beat_s && !empty_s) begin
                rd_cnt_r    <= rd_cnt_eff_s - BLEN_W'(1);
                rd_loaded_r <= 1'b1;
            end else if (!empty_s && !rd_loaded_r) begin
                rd_cnt_r    <= head_len_s;
                rd_loaded_r <= 1'b1;
            end
        end
    end

    // FIFO storage; entries are only meaningful between the pointers.
    always_ff @(posedge clk_mem) begin
        if (push_s) begin
            id_mem_r[wptr_r[PW-1:0]]  <= grant_r;
            len_mem_r[wptr_r[PW-1:0]] <= mc_cmd_burst_len_r;
        end
    end

    // Sticky error: controller fault or an unsolicited read beat.
    always_ff @(posedge clk_mem) begin
        if (rst) begin
            arb_error_r <= 1'b0;
        end else if (mc_error || (rd_beat_s && empty_s)) begin
            arb_error_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Scoreboard bench for mem_cmd_arbiter: directed requests push expected commands and beat owners,
// a negedge monitor pops and compares whenever the DUT accepts a command or a data beat moves.
module tb_mem_cmd_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int BW = 8;

    logic clk_mem = 1'b0;
    logic rst;
    logic [NR-1:0]    req_valid, req_ready, req_write, wr_owner, rd_owner;
    logic [NR*AW-1:0] req_addr;
    logic [NR*BW-1:0] req_burst_len;
    logic             mc_cmd_valid, mc_cmd_ready, mc_cmd_write;
    logic [AW-1:0]    mc_cmd_addr;
    logic [BW-1:0]    mc_cmd_burst_len;
    logic             mc_wr_valid, mc_wr_ready, mc_rd_valid, mc_rd_ready;
    logic             calibration_done, mc_error, arb_error;

    mem_cmd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .BLEN_W(BW), .RD_DEPTH(4)) dut (
        .clk_mem(clk_mem), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_burst_len(req_burst_len),
        .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready), .mc_cmd_addr(mc_cmd_addr),
        .mc_cmd_write(mc_cmd_write), .mc_cmd_burst_len(mc_cmd_burst_len),
        .mc_wr_valid(mc_wr_valid), .mc_wr_ready(mc_wr_ready),
        .mc_rd_valid(mc_rd_valid), .mc_rd_ready(mc_rd_ready),
        .calibration_done(calibration_done), .mc_error(mc_error),
        .wr_owner(wr_owner), .rd_owner(rd_owner), .arb_error(arb_error)
    );

    always #5 clk_mem = ~clk_mem;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic          wr;
        logic [BW-1:0] len;
    } cmd_t;

    cmd_t          exp_cmd[$];
    logic [NR-1:0] exp_wr[$];
    logic [NR-1:0] exp_rd[$];
    cmd_t          e;
    int            n_tot = 0;
    int            n_bad = 0;
    int            ready_pulses = 0;
    logic [NR-1:0] ready_seen = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted command and every data beat against the queues.
    always @(negedge clk_mem) begin
        ready_seen <= req_ready;
        if (req_ready != '0) ready_pulses <= ready_pulses + 1;
        if (mc_cmd_valid && mc_cmd_ready) begin
            if (exp_cmd.size() == 0) begin
                check("cmd_unexpected", {32'd0, mc_cmd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_cmd.pop_front();
                check("cmd_addr", {32'd0, mc_cmd_addr}, {32'd0, e.addr});
                check("cmd_write", {63'd0, mc_cmd_write}, {63'd0, e.wr});
                check("cmd_len", {56'd0, mc_cmd_burst_len}, {56'd0, e.len});
                check("req_ready", {60'd0, req_ready}, {60'd0, 4'b0001 << e.id});
            end
        end
        if (mc_wr_valid && mc_wr_ready && exp_wr.size() > 0)
            check("wr_owner_beat", {60'd0, wr_owner}, {60'd0, exp_wr.pop_front()});
        if (mc_rd_valid && mc_rd_ready && exp_rd.size() > 0)
            check("rd_owner_beat", {60'd0, rd_owner}, {60'd0, exp_rd.pop_front()});
    end

    task automatic tick();
        @(posedge clk_mem);
        #1;
        req_valid = req_valid & ~ready_seen;
    endtask

    task automatic request(input int id, input logic [AW-1:0] addr, input logic wr,
                           input logic [BW-1:0] len, input bit expect_it);
        cmd_t c;
        req_addr[id*AW +: AW]      = addr;
        req_write[id]              = wr;
        req_burst_len[id*BW +: BW] = len;
        req_valid[id]              = 1'b1;
        if (expect_it) begin
            c.id = id; c.addr = addr; c.wr = wr; c.len = len;
            exp_cmd.push_back(c);
            for (int b = 0; b <= int'(len); b++) begin
                if (wr) exp_wr.push_back(4'b0001 << id);
                else    exp_rd.push_back(4'b0001 << id);
            end
        end
    endtask

    task automatic wait_cmds(input string name);
        int k = 0;
        while ((exp_cmd.size() != 0 || mc_cmd_valid) && k < 60) begin
            tick();
            k++;
        end
        check(name, {63'd0, (exp_cmd.size() == 0 && !mc_cmd_valid)}, 64'd1);
    endtask

    task automatic wait_wdata(input string name);
        int k = 0;
        while (wr_owner == '0 && k < 60) begin
            tick();
            k++;
        end
        check(name, {63'd0, (wr_owner != '0)}, 64'd1);
    endtask

    task automatic wr_beats(input int n);
        mc_wr_valid = 1'b1;
        repeat (n) tick();
        mc_wr_valid = 1'b0;
    endtask

    task automatic rd_beats(input int n);
        mc_rd_valid = 1'b1;
        repeat (n) tick();
        mc_rd_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {req_ready, mc_cmd_valid, mc_cmd_write, mc_cmd_burst_len, wr_owner, rd_owner, arb_error},
              '0);
        check({name, "_addr"}, {32'd0, mc_cmd_addr}, 64'd0);
    endtask

    initial begin
        int k;
        int p0;
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_burst_len = '0;
        mc_cmd_ready = 1'b1; mc_wr_valid = 1'b0; mc_wr_ready = 1'b1;
        mc_rd_valid = 1'b0; mc_rd_ready = 1'b1; calibration_done = 1'b1; mc_error = 1'b0;
        tick(); tick();
        check_all_zero("reset_state");
        rst = 1'b0;

        // T1: round-robin order 0,1,2,3 then 0 again
        request(0, 32'h100, 1'b0, 8'd0, 1'b1);
        request(1, 32'h110, 1'b0, 8'd0, 1'b1);
        request(2, 32'h120, 1'b0, 8'd0, 1'b1);
        request(3, 32'h130, 1'b0, 8'd0, 1'b1);
        wait_cmds("t1_cmds");
        check("t1_rd_head", {60'd0, rd_owner}, 64'h1);
        rd_beats(4);
        request(0, 32'h104, 1'b0, 8'd0, 1'b1);
        wait_cmds("t1_cmd5");
        rd_beats(1);
        check("t1_rd_empty", {60'd0, rd_owner}, 64'h0);

        // T2: write lock, pending read waits for the last write beat
        request(1, 32'h200, 1'b1, 8'd3, 1'b1);
        request(2, 32'h300, 1'b0, 8'd0, 1'b1);
        wait_wdata("t2_wdata");
        check("t2_wr_owner", {60'd0, wr_owner}, 64'h2);
        wr_beats(3);
        check("t2_no_cmd_in_wdata", {63'd0, mc_cmd_valid}, 64'd0);
        wr_beats(1);
        check("t2_owner_cleared", {60'd0, wr_owner}, 64'h0);
        check("t2_not_yet_issued", {63'd0, mc_cmd_valid}, 64'd0);
        tick();
        check("t2_read_issued", {63'd0, mc_cmd_valid}, 64'd1);
        wait_cmds("t2_cmds");
        rd_beats(1);

        // T3: full read FIFO masks reads but not writes
        request(3, 32'h400, 1'b0, 8'd0, 1'b1);
        request(0, 32'h410, 1'b0, 8'd0, 1'b1);
        request(1, 32'h420, 1'b0, 8'd0, 1'b1);
        request(2, 32'h430, 1'b0, 8'd0, 1'b1);
        wait_cmds("t3_fill");
        request(0, 32'h500, 1'b1, 8'd0, 1'b1);
        request(3, 32'h440, 1'b0, 8'd0, 1'b1);
        wait_wdata("t3_write_first");
        wr_beats(1);
        tick(); tick();
        check("t3_read_masked", {63'd0, mc_cmd_valid}, 64'd0);
        rd_beats(1);
        wait_cmds("t3_read_after_pop");
        rd_beats(4);
        check("t3_rd_empty", {60'd0, rd_owner}, 64'h0);

        // T4: command backpressure
        mc_cmd_ready = 1'b0;
        request(0, 32'h600, 1'b0, 8'd5, 1'b1);
        k = 0;
        while (!mc_cmd_valid && k < 20) begin tick(); k++; end
        p0 = ready_pulses;
        for (int s = 0; s < 5; s++) begin
            check("t4_stall_fields", {mc_cmd_valid, mc_cmd_write, mc_cmd_burst_len, req_ready, mc_cmd_addr},
                  {1'b1, 1'b0, 8'd5, 4'd0, 32'h600});
            tick();
        end
        mc_cmd_ready = 1'b1;
        tick(); tick();
        check("t4_valid_dropped", {63'd0, mc_cmd_valid}, 64'd0);
        check("t4_ready_pulses", ready_pulses - p0, 64'd1);
        rd_beats(6);

        // T5a: no grants before calibration
        calibration_done = 1'b0;
        request(1, 32'h700, 1'b0, 8'd0, 1'b1);
        repeat (4) tick();
        check("t5a_uncalibrated", {63'd0, mc_cmd_valid}, 64'd0);
        calibration_done = 1'b1;
        wait_cmds("t5a_after_cal");
        rd_beats(1);

        // T5b: unsolicited read beat latches the error and blocks grants
        check("t5b_err_clear", {63'd0, arb_error}, 64'd0);
        rd_beats(1);
        check("t5b_err_set", {63'd0, arb_error}, 64'd1);
        request(2, 32'h800, 1'b0, 8'd0, 1'b0);
        repeat (4) tick();
        check("t5b_no_grant", {63'd0, mc_cmd_valid}, 64'd0);

        // T5c: reset clears everything; mc_error also latches
        req_valid = '0;
        rst = 1'b1;
        tick();
        check_all_zero("t5c_reset");
        rst = 1'b0;
        mc_error = 1'b1;
        tick();
        mc_error = 1'b0;
        check("t5c_mc_error", {63'd0, arb_error}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5c_err_cleared", {63'd0, arb_error}, 64'd0);

        // T6: reset in the middle of a write burst
        request(1, 32'h900, 1'b1, 8'd7, 1'b1);
        wait_wdata("t6_wdata");
        wr_beats(2);
        mc_wr_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mc_wr_valid = 1'b0;
        check("t6_wr_owner_zero", {60'd0, wr_owner}, 64'h0);
        check("t6_cmd_idle", {63'd0, mc_cmd_valid}, 64'd0);
        exp_wr.delete();
        request(0, 32'hA10, 1'b1, 8'd0, 1'b1);
        request(2, 32'hA20, 1'b1, 8'd0, 1'b1);
        wait_wdata("t6_first_write");
        wr_beats(1);
        wait_wdata("t6_second_write");
        wr_beats(1);
        wait_cmds("t6_cmds");
        check("t6_wr_done", {60'd0, wr_owner}, 64'h0);

        check("queues_drained", exp_cmd.size() + exp_wr.size() + exp_rd.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
